// File: rtl/addsub_pipe.sv
// ---------------------------------------------------------------------------
// addsub_pipe -- carry-pipelined adder/subtractor with C/V/Z/N flags.
//
// Operands are cut into NSEG = WIDTH/SEG_W segments. Stage k resolves
// segment k-1 with a G/P lookahead (addsub_seg) and registers its carry
// for the next stage. No carry ripples across segment boundaries within a
// cycle. Operand bits not yet consumed and result segments already produced
// travel forward with the carry, so the last stage holds the full result.
// Flags are computed as the last segment is resolved and are registered
// together with the result.
//
// Flow control is a global stall: every stage advances together when the
// output is empty or being taken (advance = !out_valid || out_ready).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operation handshake (a, b, cin, op sampled on accept)
//   a, b                  WIDTH-bit operands
//   cin                   carry/borrow-in, used only by ADC/SBB
//   op                    00 ADD, 01 SUB, 10 ADC, 11 SBB
//   out_valid / out_ready result handshake
//   result                WIDTH-bit sum/difference
//   flag_c/v/z/n          carry (1 = no borrow on subtract), overflow, zero, sign
// ---------------------------------------------------------------------------

// One SEG_W-bit lookahead group. Every carry is a flat sum of products of
// generate/propagate terms and the group carry-in, so there is no internal
// ripple chain. o_cm is the carry into the top bit of the group, which the
// last segment needs for signed overflow.
module addsub_seg #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] i_a,
  input  logic [SEG_W-1:0] i_b,
  input  logic             i_ci,
  output logic [SEG_W-1:0] o_s,
  output logic             o_co,
  output logic             o_cm
);
  logic [SEG_W-1:0] w_g, w_p;
  logic [SEG_W:0]   w_c;
  logic             w_term_g, w_term_p;

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]ci
  always_comb begin
    w_g      = i_a & i_b;
    w_p      = i_a ^ i_b;
    w_c      = '0;
    w_c[0]   = i_ci;
    w_term_g = 1'b0;
    w_term_p = 1'b0;
    for (int i = 0; i < SEG_W; i++) begin
      w_term_g = w_g[i];
      w_term_p = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_term_g = w_term_g | (w_term_p & w_g[j]);
        w_term_p = w_term_p & w_p[j];
      end
      w_c[i+1] = w_term_g | (w_term_p & i_ci);
    end
  end

  assign o_s  = w_p ^ w_c[SEG_W-1:0];
  assign o_co = w_c[SEG_W];
  assign o_cm = w_c[SEG_W-1];
endmodule

module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);
  // Pipeline depth; guarded so a bad SEG_W reaches the error below instead
  // of a divide-by-zero.
  localparam int NSEG = (SEG_W > 0) ? WIDTH / SEG_W : 1;

  generate
    if (SEG_W < 1) begin : g_err_segw
      $error("addsub_pipe: SEG_W must be >= 1");
    end else if (WIDTH % SEG_W != 0) begin : g_err_width
      $error("addsub_pipe: WIDTH must be a multiple of SEG_W");
    end
  endgenerate

  // Control
  logic            w_adv, w_acc;
  logic [NSEG-1:0] r_vld_pipe;   // r_vld_pipe[k]: stage k+1 holds an op
  logic [NSEG-1:0] w_vin;        // valid arriving at stage k+1 on advance

  // Effective operands for segment 0
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  // Segment k inputs/outputs. Index k of the r_* arrays is the register
  // feeding segment k (index 0 is fed straight from the ports).
  logic [WIDTH-1:0] w_ain [NSEG];
  logic [WIDTH-1:0] w_bin [NSEG];
  logic [WIDTH-1:0] w_sin [NSEG];
  logic [WIDTH-1:0] w_sout[NSEG];
  logic [NSEG-1:0]  w_ci, w_co;
  logic [NSEG-1:0][SEG_W-1:0] w_s;
  logic             w_cm  [NSEG];

  logic [WIDTH-1:0] r_a [NSEG];
  logic [WIDTH-1:0] r_b [NSEG];
  logic [WIDTH-1:0] r_s [NSEG];
  logic             r_c [NSEG];

  // Final stage
  logic [WIDTH-1:0] r_result;
  logic             r_fc, r_fv, r_fz, r_fn;

  assign w_adv    = !r_vld_pipe[NSEG-1] || out_ready;
  assign in_ready = w_adv && !rst;
  assign w_acc    = in_valid && in_ready;

  // SUB/SBB invert B; carry-in is 0/1 for ADD/SUB and cin for ADC/SBB.
  assign w_b_eff = op[0] ? ~b : b;
  assign w_c0    = op[1] ? cin : op[0];

  always_comb begin
    w_vin[0] = w_acc;
    w_ain[0] = a;
    w_bin[0] = w_b_eff;
    w_sin[0] = '0;
    w_ci[0]  = w_c0;
    for (int k = 1; k < NSEG; k++) begin
      w_vin[k] = r_vld_pipe[k-1];
      w_ain[k] = r_a[k];
      w_bin[k] = r_b[k];
      w_sin[k] = r_s[k];
      w_ci[k]  = r_c[k];
    end
  end

  // Partial result: lower segments from earlier stages plus this one.
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      w_sout[k] = w_sin[k];
      w_sout[k][k*SEG_W +: SEG_W] = w_s[k];
    end
  end

  generate
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
      addsub_seg #(.SEG_W(SEG_W)) u_seg (
        .i_a  (w_ain[k][k*SEG_W +: SEG_W]),
        .i_b  (w_bin[k][k*SEG_W +: SEG_W]),
        .i_ci (w_ci[k]),
        .o_s  (w_s[k]),
        .o_co (w_co[k]),
        .o_cm (w_cm[k])
      );
    end
  endgenerate

  // Datapath between stages. Carries no reset: a register is only ever
  // observed behind a valid bit, and the valid bits are cleared on reset.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int k = 0; k < NSEG - 1; k++) begin
        r_a[k+1] <= w_ain[k];
        r_b[k+1] <= w_bin[k];
        r_s[k+1] <= w_sout[k];
        r_c[k+1] <= w_co[k];
      end
    end
  end

  // Valid shift register and output stage. The output registers only load
  // on a real op, so a bubble leaves the last result (or the reset zeros)
  // in place while out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      r_result   <= '0;
      r_fc       <= 1'b0;
      r_fv       <= 1'b0;
      r_fz       <= 1'b0;
      r_fn       <= 1'b0;
    end else if (w_adv) begin
      r_vld_pipe <= w_vin;
      if (w_vin[NSEG-1]) begin
        r_result <= w_sout[NSEG-1];
        r_fc     <= w_co[NSEG-1];
        r_fv     <= w_cm[NSEG-1] ^ w_co[NSEG-1];
        r_fz     <= ~|w_sout[NSEG-1];
        r_fn     <= w_sout[NSEG-1][WIDTH-1];
      end
    end
  end

  assign out_valid = r_vld_pipe[NSEG-1];
  assign result    = r_result;
  assign flag_c    = r_fc;
  assign flag_v    = r_fv;
  assign flag_z    = r_fz;
  assign flag_n    = r_fn;
endmodule

// File: tb/tb_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_addsub_pipe -- self-checking bench for addsub_pipe (WIDTH=16, SEG_W=4).
// Directed vector table with latency checks, an 8-op stream under a toggling
// out_ready, a mid-flight reset, and randomized traffic scored against an
// integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, out_valid, out_ready;
  logic        flag_c, flag_v, flag_z, flag_n;
  logic [15:0] a, b, result;
  logic [1:0]  op;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(16), .SEG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] res;
    logic        c, v, z, n;
  } vec_t;

  int          checks = 0, failures = 0, delivered = 0;
  logic [19:0] q[$];          // expected {result, c, v, z, n} in order
  logic        stall_prev = 1'b0;
  logic [20:0] stall_snap;
  logic [15:0] corners[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [19:0] model(input logic [1:0] fop, input logic [15:0] fa,
                                        input logic [15:0] fb, input logic fcin);
    int ua, ub, sa, sb, ut, st, ci;
    logic [15:0] r;
    logic c, v;
    ua = int'(fa); ub = int'(fb);
    sa = int'($signed(fa)); sb = int'($signed(fb));
    ci = fcin ? 1 : 0;
    case (fop)
      2'b00:   begin ut = ua + ub;          st = sa + sb;          c = (ut > 65535); end
      2'b01:   begin ut = ua - ub;          st = sa - sb;          c = (ut >= 0);    end
      2'b10:   begin ut = ua + ub + ci;     st = sa + sb + ci;     c = (ut > 65535); end
      default: begin ut = ua - ub - 1 + ci; st = sa - sb - 1 + ci; c = (ut >= 0);    end
    endcase
    r = ut[15:0];
    v = (st > 32767) || (st < -32768);
    return {r, c, v, (r == 16'h0000), r[15]};
  endfunction

  function automatic logic [19:0] outs();
    return {result, flag_c, flag_v, flag_z, flag_n};
  endfunction

  // One clock of streaming traffic with scoreboard and handshake checks.
  task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic [1:0] iop, input logic icin, input logic ordy,
                       output logic acc);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; op = iop; cin = icin; out_ready = ordy;
    #1;
    if (stall_prev) chk("stall_stable", {out_valid, outs()}, stall_snap);
    chk("in_ready_rule", in_ready, !out_valid || out_ready);
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        chk("stream_result", outs(), q.pop_front());
        delivered++;
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_snap = {out_valid, outs()};
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(iop, ia, ib, icin));
  endtask

  task automatic drain(input string nm);
    logic acc;
    for (int i = 0; i < 40 && (q.size() != 0 || out_valid); i++)
      cycle(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1, acc);
    chk({nm, "_drained"}, q.size(), 0);
  endtask

  // Single op on an empty pipe: accepted at edge t, absent after t+2,
  // present after t+3.
  task automatic run_one(input string nm, input vec_t v);
    stall_prev = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; a = v.a; b = v.b; op = v.op; cin = v.cin; out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_not_early"}, out_valid, 0);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_out"}, outs(), {v.res, v.c, v.v, v.z, v.n});
  endtask

  initial begin
    vec_t vecs[7];
    logic acc;
    int   issued, base;

    vecs[0] = '{2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{2'b11, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{2'b10, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{2'b00, 16'h7FFF, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b01, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", outs(), 0);
    rst = 1'b0;
    #1 chk("rel_in_ready", in_ready, 1);

    // Directed table
    for (int i = 0; i < 7; i++) run_one($sformatf("vec%0d", i), vecs[i]);

    // Eight back-to-back ADDs, out_ready toggling 1,0,1,0...
    stall_prev = 1'b0;
    issued = 0;
    base = delivered;
    for (int c = 0; c < 60 && issued < 8; c++) begin
      cycle(1'b1, 16'(issued), 16'(16'h1000 * issued), 2'b00, 1'b0, (c % 2) == 0, acc);
      if (acc) issued++;
    end
    for (int c = 0; c < 40 && q.size() != 0; c++)
      cycle(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, (c % 2) == 0, acc);
    drain("stream8");
    chk("stream8_count", delivered - base, 8);

    // Reset with three ops in flight
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 16'(16'h0101 * (i + 1)), 16'h0011, 2'b00, 1'b0, 1'b1, acc);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
    #1 chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outs", outs(), 0);
    rst = 1'b0; in_valid = 1'b0;
    q.delete();
    stall_prev = 1'b0;
    #1 chk("midrst_rel_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1, acc);
      chk("midrst_no_stale", out_valid, 0);
    end
    run_one("post_rst", vecs[1]);

    // Randomized traffic with random back-pressure
    stall_prev = 1'b0;
    base = delivered;
    issued = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [15:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
      cycle(($urandom % 4) != 0, ra, rb, 2'($urandom), 1'($urandom),
            ($urandom % 3) != 0, acc);
      if (acc) issued++;
    end
    drain("random");
    chk("random_count", delivered - base, issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, carry-pipelined adder/subtractor. It is the next generation of the team's 4-bit carry-lookahead adder.
- Operands are split into SEG_W-bit segments. Each pipeline stage resolves one segment with a lookahead carry and registers the carry into the next stage.
- The block streams one operation per cycle under a valid/ready handshake and produces C/V/Z/N flags.
- It sits between the operand-select logic and the ALU result mux.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SEG_W.
- SEG_W, 4, bits resolved per stage (internal lookahead group width).
- NSEG, WIDTH/SEG_W (derived, not overridable), pipeline depth = latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation present on inputs.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry/borrow input, used by ADC/SBB only.
- op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  downstream accepts result.
- result  out  WIDTH  sum/difference.
- flag_c  out  1  carry out of MSB; for SUB/SBB, 1 = no borrow.
- flag_v  out  1  signed overflow.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].

Behaviour:
- Single clock domain. Reset is synchronous, active-high, on clk.
- Operation mapping:
  - Effective B: b for ADD/ADC, ~b for SUB/SBB.
  - Effective carry-in: 0 for ADD, 1 for SUB, cin for ADC, cin for SBB.
  - Arithmetic is modulo 2^WIDTH; all flags derive from the full-width result.
- Pipeline structure: NSEG stages, S1..SNSEG.
  - Accept occurs when in_valid && in_ready on a rising edge.
  - On accept, segment 0 is computed combinationally from the ports and written to S1.
  - Stage k computes segment k-1 from its delayed operand bits and the registered carry of stage k-1.
  - Lower result segments and upper operand segments are skewed forward so that SNSEG holds the complete result.
  - Carry within a segment: G/P lookahead, no ripple across segments within one cycle.
- Latency: an operation accepted at edge t appears on the outputs immediately after edge t+NSEG-1 and stays until handed off.
- Throughput: 1 op/cycle when out_ready is held high.
- Handshake (global-stall pipeline):
  - advance = !out_valid || out_ready.
  - in_ready = advance && !rst.
  - When advance = 0, every stage holds: outputs are stable and no stage is overwritten.
  - Bubbles (stages without valid) propagate normally.
  - Handoff occurs on an edge with out_valid && out_ready. If no new valid reaches SNSEG on that edge, out_valid drops.
- Flags, computed at the final stage:
  - flag_c = carry out of bit WIDTH-1.
  - flag_v = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - flag_z = ~|result.
  - flag_n = result[WIDTH-1].
- Reset behaviour: on any edge with rst = 1:
  - all stage valid bits clear; result and all flags become 0; out_valid becomes 0.
  - in-flight operations are discarded, including mid-pipeline ones; nothing stale emerges after release.
  - in_ready is 0 while rst = 1 and 1 on the first cycle after release.
- Simultaneous events:
  - Accept and handoff on the same edge is legal and loses nothing.
  - rst wins over any accept or handoff on the same edge.
- Inputs are ignored when !in_valid or !in_ready. op, cin, a and b are sampled only on the accepting edge (delayed internally).
- Elaboration error if WIDTH % SEG_W != 0 or SEG_W < 1.

Test Plan (WIDTH=16, SEG_W=4, NSEG=4, out_ready=1 unless stated):
1. ADD a=0x00FF, b=0x0001, accepted edge t -> result 0x0100 valid from edge t+3; C=0 V=0 Z=0 N=0.
2. ADD a=0xFFFF, b=0x0001 -> result 0x0000, C=1, Z=1, V=0, N=0 (carry crosses all four segment registers).
3. SUB a=0x8000, b=0x0001 -> 0x7FFF, C=1, V=1, N=0, Z=0. Also SBB a=0x0000, b=0x0001, cin=1 -> 0xFFFF, C=0, N=1, V=0.
4. ADC a=0x7FFF, b=0x0000, cin=1 -> 0x8000, C=0, V=1, N=1. Same with op=ADD -> 0x7FFF, V=0 (cin ignored).
5. Stream 8 back-to-back ADDs (a=i, b=0x1000*i) with out_ready toggling 1,0,1,0...:
   - all 8 results emerge in order with no duplicates or drops;
   - in_ready is low exactly when out_valid && !out_ready;
   - result/flags are stable during stall cycles.
6. Accept 3 ops, assert rst for 1 cycle mid-flight:
   - out_valid = 0, result = 0, flags = 0 next cycle; in_ready = 0 during rst;
   - after release, no output appears until a new op is accepted, which then completes with correct 4-cycle latency.
